// File: rtl/pci_simple_target.sv
// pci_simple_target: 32-bit PCI target with a type-0 config space and one BAR0 memory window backed by word RAM.
// Define PCI_TGT_PARITY_CHECK_EN to enable address/write-data parity checking with PERR# reporting.
module pci_simple_target #(
  parameter logic [15:0] VENDOR_ID = 16'h10EE,
  parameter logic [15:0] DEVICE_ID = 16'h6120,
  parameter int unsigned MEM_AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ad_i,
  output logic [31:0] ad_o,
  output logic        ad_oe,
  input  logic [3:0]  cbe_n_i,
  input  logic        frame_n_i,
  input  logic        irdy_n_i,
  input  logic        idsel_i,
  input  logic        par_i,
  output logic        par_o,
  output logic        par_oe,
  output logic        devsel_n_o,
  output logic        trdy_n_o,
  output logic        stop_n_o,
  output logic        ctl_oe,
  output logic        perr_n_o,
  output logic        perr_oe
);

  localparam int unsigned WORDS    = 2 ** MEM_AW;
  localparam logic [31:0] BAR_MASK = ~((32'd1 << (MEM_AW + 2)) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLAIM, S_WDATA, S_RWAIT, S_RDATA, S_DISC, S_TURN, S_BUSY
  } state_e;

  state_e              state_q, state_d;
  logic                frame_q;
  logic [MEM_AW-1:0]   addr_q, addr_d, addr_inc;
  logic                cfg_q, cfg_d;
  logic                wr_q, wr_d;
  logic [5:0]          cfg_idx_q, cfg_idx_d;
  logic                mem_en_q, mem_en_d;
  logic [31:0]         bar_q, bar_d;
  logic [31:0]         ad_o_q, ad_o_d;
  logic                ad_oe_q, ad_oe_d;
  logic                par_o_q, par_oe_q;
  logic                devsel_n_q, devsel_n_d;
  logic                trdy_n_q, trdy_n_d;
  logic                stop_n_q, stop_n_d;
  logic                ctl_oe_q, ctl_oe_d;
  logic [31:0]         cfg_rdata;
  logic                cfg_hit, mem_hit, xfer, wr_xfer, mem_we, addr_perr;
  logic [31:0]         mem_q [WORDS];

  assign cfg_hit = idsel_i && (cbe_n_i == 4'hA || cbe_n_i == 4'hB) && (ad_i[1:0] == 2'b00);
  assign mem_hit = (cbe_n_i inside {4'h6, 4'h7, 4'hC, 4'hE, 4'hF}) && mem_en_q &&
                   (ad_i[31:MEM_AW+2] == bar_q[31:MEM_AW+2]);
  assign xfer    = !irdy_n_i && !trdy_n_q;
  assign wr_xfer = (state_q == S_WDATA) && xfer;
  assign mem_we  = wr_xfer && !cfg_q && !rst;

  always_comb begin
    case (cfg_idx_q)
      6'd0:    cfg_rdata = {DEVICE_ID, VENDOR_ID};
      6'd1:    cfg_rdata = {30'd0, mem_en_q, 1'b0};
      6'd4:    cfg_rdata = bar_q;
      default: cfg_rdata = 32'd0;
    endcase
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cfg_d      = cfg_q;
    wr_d       = wr_q;
    cfg_idx_d  = cfg_idx_q;
    mem_en_d   = mem_en_q;
    bar_d      = bar_q;
    ad_o_d     = ad_o_q;
    ad_oe_d    = ad_oe_q;
    devsel_n_d = devsel_n_q;
    trdy_n_d   = trdy_n_q;
    stop_n_d   = stop_n_q;
    ctl_oe_d   = ctl_oe_q;
    addr_inc   = addr_q + MEM_AW'(1);

    case (state_q)
      S_IDLE: begin
        if (!frame_n_i && frame_q) begin
          addr_d    = ad_i[MEM_AW+1:2];
          cfg_idx_d = ad_i[7:2];
          cfg_d     = cfg_hit;
          wr_d      = cbe_n_i[0];
          state_d   = (cfg_hit || mem_hit) ? S_CLAIM : S_BUSY;
        end
      end
      S_CLAIM: begin
        if (addr_perr) begin
          state_d = S_BUSY;
        end else begin
          devsel_n_d = 1'b0;
          ctl_oe_d   = 1'b1;
          if (wr_q) begin
            trdy_n_d = 1'b0;
            stop_n_d = ~(cfg_q || (&addr_q));
            state_d  = S_WDATA;
          end else begin
            ad_oe_d = 1'b1;
            state_d = S_RWAIT;
          end
        end
      end
      S_RWAIT: begin
        trdy_n_d = 1'b0;
        stop_n_d = ~(cfg_q || (&addr_q));
        ad_o_d   = cfg_q ? cfg_rdata : mem_q[addr_q];
        state_d  = S_RDATA;
      end
      S_WDATA, S_RDATA: begin
        if (xfer) begin
          addr_d = addr_inc;
          if (state_q == S_RDATA) begin
            ad_o_d = mem_q[addr_inc];
          end else if (cfg_q) begin
            if (cfg_idx_q == 6'd1 && !cbe_n_i[0]) mem_en_d = ad_i[1];
            if (cfg_idx_q == 6'd4) begin
              for (int b = 0; b < 4; b++) begin
                if (!cbe_n_i[b]) bar_d[8*b +: 8] = ad_i[8*b +: 8] & BAR_MASK[8*b +: 8];
              end
            end
          end
          if (frame_n_i) begin
            devsel_n_d = 1'b1;
            trdy_n_d   = 1'b1;
            stop_n_d   = 1'b1;
            ad_oe_d    = 1'b0;
            state_d    = S_TURN;
          end else if (!stop_n_q) begin
            // Disconnect-with-data: one word taken, then hold STOP until FRAME# rises
            trdy_n_d = 1'b1;
            state_d  = S_DISC;
          end else begin
            stop_n_d = ~(&addr_inc);
          end
        end
      end
      S_DISC: begin
        if (frame_n_i) begin
          devsel_n_d = 1'b1;
          trdy_n_d   = 1'b1;
          stop_n_d   = 1'b1;
          ad_oe_d    = 1'b0;
          state_d    = S_TURN;
        end
      end
      S_TURN: begin
        ctl_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
      S_BUSY: begin
        if (frame_n_i && irdy_n_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_q    <= 1'b1;
      addr_q     <= '0;
      cfg_q      <= 1'b0;
      wr_q       <= 1'b0;
      cfg_idx_q  <= '0;
      mem_en_q   <= 1'b0;
      bar_q      <= '0;
      ad_o_q     <= '0;
      ad_oe_q    <= 1'b0;
      par_o_q    <= 1'b0;
      par_oe_q   <= 1'b0;
      devsel_n_q <= 1'b1;
      trdy_n_q   <= 1'b1;
      stop_n_q   <= 1'b1;
      ctl_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_n_i;
      addr_q     <= addr_d;
      cfg_q      <= cfg_d;
      wr_q       <= wr_d;
      cfg_idx_q  <= cfg_idx_d;
      mem_en_q   <= mem_en_d;
      bar_q      <= bar_d;
      ad_o_q     <= ad_o_d;
      ad_oe_q    <= ad_oe_d;
      par_o_q    <= ^{ad_o_q, cbe_n_i};
      par_oe_q   <= ad_oe_q;
      devsel_n_q <= devsel_n_d;
      trdy_n_q   <= trdy_n_d;
      stop_n_q   <= stop_n_d;
      ctl_oe_q   <= ctl_oe_d;
    end
  end

  // Byte-merging RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!cbe_n_i[b]) mem_q[addr_q][8*b +: 8] <= ad_i[8*b +: 8];
      end
    end
  end

`ifdef PCI_TGT_PARITY_CHECK_EN
  logic par_exp_q, wr_xfer_q, err_q, perr_n_q, perr_oe_q;

  // PAR arrives one clock after the AD/CBE it covers
  always_ff @(posedge clk) begin
    if (rst) begin
      par_exp_q <= 1'b0;
      wr_xfer_q <= 1'b0;
      err_q     <= 1'b0;
      perr_n_q  <= 1'b1;
      perr_oe_q <= 1'b0;
    end else begin
      par_exp_q <= ^{ad_i, cbe_n_i};
      wr_xfer_q <= wr_xfer;
      err_q     <= wr_xfer_q && (par_i != par_exp_q);
      perr_n_q  <= ~err_q;
      perr_oe_q <= err_q || !perr_n_q;
    end
  end

  assign addr_perr = (par_i != par_exp_q);
  assign perr_n_o  = perr_n_q;
  assign perr_oe   = perr_oe_q;
`else
  logic unused_par;
  assign unused_par = par_i;
  assign addr_perr  = 1'b0;
  assign perr_n_o   = 1'b1;
  assign perr_oe    = 1'b0;
`endif

  assign ad_o       = ad_o_q;
  assign ad_oe      = ad_oe_q;
  assign par_o      = par_o_q;
  assign par_oe     = par_oe_q;
  assign devsel_n_o = devsel_n_q;
  assign trdy_n_o   = trdy_n_q;
  assign stop_n_o   = stop_n_q;
  assign ctl_oe     = ctl_oe_q;

endmodule
